// File: rtl/complex_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : complex_wb_buffer
//  Description : Writeback buffer for the complex execution lane. Accepted
//                results ride a fixed LAT-stage delay line (which never
//                stalls), then land in a DEPTH-entry FIFO that feeds the
//                writeback stage over a valid/ready handshake. A credit
//                counter covers delay line + FIFO, so an arriving result
//                always finds a free FIFO slot.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : sole clock, rising edge
//    reset        : synchronous, active-high
//    in_valid     : complex-lane result offered
//    in_ready     : buffer has a credit free (occupancy < DEPTH)
//    in_tag       : destination tag of offered result
//    in_result    : full-width result; only the low SIZE_DATA bits are kept
//    in_flags     : flags (bit2 executed, bit1 exception, bit0 mispredict)
//    wb_valid     : head packet present
//    wb_ready     : writeback stage consumes the head packet
//    wb_tag       : head tag (0 when empty)
//    wb_data      : head data word (0 when empty)
//    wb_flags     : head flags (0 when empty)
//    wb_exception : wb_flags[1] qualified by wb_valid
// ============================================================================
module complex_wb_buffer #(
    parameter int SIZE_DATA       = 32,
    parameter int SIZE_TAG        = 7,
    parameter int EXECUTION_FLAGS = 6,
    parameter int LAT             = 3,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIZE_TAG-1:0]        in_tag,
    input  logic [2*SIZE_DATA-1:0]     in_result,
    input  logic [EXECUTION_FLAGS-1:0] in_flags,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [SIZE_TAG-1:0]        wb_tag,
    output logic [SIZE_DATA-1:0]       wb_data,
    output logic [EXECUTION_FLAGS-1:0] wb_flags,
    output logic                       wb_exception
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = SIZE_TAG + SIZE_DATA + EXECUTION_FLAGS;

    localparam logic [OCC_W-1:0] c_depth   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    // Entry layout: {tag, data, flags}
    logic [ENTRY_W-1:0]         w_in_entry;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_push;
    logic [ENTRY_W-1:0]         w_arrive_entry;
    logic [ENTRY_W-1:0]         w_head;
    logic                       w_unused_result_hi;

    // Delay line kept as packed shift registers: stage 0 in the low bits,
    // the oldest stage in the high bits. Concatenating the incoming entry
    // below the register gives the next state in the low part and the
    // entry leaving the last stage in the top slice, for any LAT >= 1.
    logic [LAT-1:0]             r_dl_valid;
    logic [LAT*ENTRY_W-1:0]     r_dl_entry;
    logic [LAT:0]               w_dl_valid_shift;
    logic [(LAT+1)*ENTRY_W-1:0] w_dl_entry_shift;

    logic [ENTRY_W-1:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [OCC_W-1:0]           r_count;
    logic [OCC_W-1:0]           r_occ;

    assign w_unused_result_hi = ^in_result[2*SIZE_DATA-1:SIZE_DATA];

    assign w_in_entry = {in_tag, in_result[SIZE_DATA-1:0], in_flags};
    assign in_ready   = (r_occ < c_depth);
    assign w_in_fire  = in_valid & in_ready;
    assign wb_valid   = (r_count != '0);
    assign w_out_fire = wb_valid & wb_ready;

    assign w_dl_valid_shift = {r_dl_valid, w_in_fire};
    assign w_dl_entry_shift = {r_dl_entry, w_in_entry};
    assign w_push           = w_dl_valid_shift[LAT];
    assign w_arrive_entry   = w_dl_entry_shift[(LAT+1)*ENTRY_W-1 -: ENTRY_W];

    // Control state: delay-line valids, FIFO pointers/count, credits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_valid <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_occ      <= '0;
        end else begin
            r_dl_valid <= w_dl_valid_shift[LAT-1:0];

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_out_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_push, w_out_fire})
                2'b10:   r_count <= r_count + c_occ_one;
                2'b01:   r_count <= r_count - c_occ_one;
                default: r_count <= r_count;
            endcase

            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + c_occ_one;
                2'b01:   r_occ <= r_occ - c_occ_one;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset: every consumer is qualified by a
    // valid bit or the FIFO count.
    always_ff @(posedge clk) begin
        r_dl_entry <= w_dl_entry_shift[LAT*ENTRY_W-1:0];
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_arrive_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Payload is forced to zero when empty so nothing stale is visible
    // after reset or after the FIFO drains.
    assign wb_tag       = wb_valid ? w_head[ENTRY_W-1 -: SIZE_TAG] : '0;
    assign wb_data      = wb_valid ? w_head[SIZE_DATA+EXECUTION_FLAGS-1 -: SIZE_DATA] : '0;
    assign wb_flags     = wb_valid ? w_head[EXECUTION_FLAGS-1:0] : '0;
    assign wb_exception = wb_valid & wb_flags[1];

    // The credit counter makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_out_fire && (r_count == c_depth)));

endmodule
`default_nettype wire
